// File: rtl/gol_display_scan.sv
// Raster scan-out for the 8x8 Game-of-Life grid: video timing, cell rendering and a
// double-buffered generation word that is swapped only at the start of vertical blank.
module gol_display_scan #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          CELL_PX   = 60,
    parameter logic [23:0] LIVE_RGB  = 24'hFFFFFF,
    parameter logic [23:0] DEAD_RGB  = 24'h000000,
    parameter logic [23:0] BG_RGB    = 24'h202020,
    parameter bit          BORDER_EN = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_start,
    input  logic [63:0] i_grid_in,
    input  logic        i_grid_valid,
    output logic        o_frame_done,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [23:0] o_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SWAP   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(CELL_PX - 1);

    if (8 * CELL_PX > H_ACTIVE || 8 * CELL_PX > V_ACTIVE) begin : g_bad_cell_px
        $error("gol_display_scan: 8*CELL_PX must fit in the active area");
    end

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [SW-1:0] r_sx;
    logic [SW-1:0] r_sy;
    logic [3:0]    r_cx;
    logic [3:0]    r_cy;
    logic [63:0]   r_pend;
    logic [63:0]   r_disp;
    logic          r_pend_v;

    logic          w_line_end;
    logic          w_swap;
    logic          w_active;
    logic [5:0]    w_cell_idx;
    logic [23:0]   w_rgb;

    assign w_line_end = (r_hcnt == H_LAST);
    assign w_swap     = w_line_end && (r_vcnt == V_SWAP);
    assign w_active   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);

    // Cell indices saturate at 8: anything at or beyond 8 is simply "outside the grid".
    always_ff @(posedge i_clk or posedge i_start) begin
        if (i_start) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
        end else if (w_line_end) begin
            r_hcnt <= '0;
            r_sx   <= '0;
            r_cx   <= '0;
            if (r_vcnt == V_LAST) begin
                r_vcnt <= '0;
                r_sy   <= '0;
                r_cy   <= '0;
            end else begin
                r_vcnt <= r_vcnt + 1'b1;
                if (r_sy == S_LAST) begin
                    r_sy <= '0;
                    if (r_cy < 4'd8) r_cy <= r_cy + 4'd1;
                end else begin
                    r_sy <= r_sy + 1'b1;
                end
            end
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
            if (r_sx == S_LAST) begin
                r_sx <= '0;
                if (r_cx < 4'd8) r_cx <= r_cx + 4'd1;
            end else begin
                r_sx <= r_sx + 1'b1;
            end
        end
    end

    // A strobe on the swap cycle loses to nothing: the swap takes the old pend, the new word waits.
    always_ff @(posedge i_clk or posedge i_start) begin
        if (i_start) begin
            r_pend   <= '0;
            r_disp   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            if (w_swap && r_pend_v) begin
                r_disp   <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (i_grid_valid) begin
                r_pend   <= i_grid_in;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign w_cell_idx = 6'd63 - {r_cy[2:0], r_cx[2:0]};

    always_comb begin
        w_rgb = '0;
        if (!w_active)
            w_rgb = '0;
        else if (r_cx[3] || r_cy[3])
            w_rgb = BG_RGB;
        else if (BORDER_EN && (r_sx == '0 || r_sy == '0))
            w_rgb = BG_RGB;
        else
            w_rgb = r_disp[w_cell_idx] ? LIVE_RGB : DEAD_RGB;
    end

    always_ff @(posedge i_clk or posedge i_start) begin
        if (i_start) begin
            o_de         <= 1'b0;
            o_hsync      <= 1'b1;
            o_vsync      <= 1'b1;
            o_rgb        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_de         <= w_active;
            o_hsync      <= !((r_hcnt >= H_SYNC_S) && (r_hcnt <= H_SYNC_E));
            o_vsync      <= !((r_vcnt >= V_SYNC_S) && (r_vcnt <= V_SYNC_E));
            o_rgb        <= w_rgb;
            o_frame_done <= w_swap;
        end
    end

endmodule

// File: tb/tb_gol_display_scan.sv
// Bench for gol_display_scan on a shrunk 22x19 raster: a per-cycle reference model plus
// directed strobes and hand-computed pixel checks.
module tb_gol_display_scan;

    localparam int HT = 22;
    localparam int VT = 19;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        start;
    logic [63:0] gridIn;
    logic        gridValid;

    logic        fdM, deM, hsM, vsM;
    logic [23:0] rgbM;
    logic        fdU, deU, hsU, vsU;
    logic [23:0] rgbU;

    int testsRun  = 0;
    int failCount = 0;
    int tCnt      = 0;
    int lastPos   = -1;

    logic [63:0] mDisp [2];
    logic [63:0] mPend [2];
    bit          mPendV[2];

    always #5 clk = ~clk;

    gol_display_scan #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CELL_PX(2), .BORDER_EN(1'b0)
    ) dutMain (
        .i_clk(clk), .i_start(start), .i_grid_in(gridIn), .i_grid_valid(gridValid),
        .o_frame_done(fdM), .o_de(deM), .o_hsync(hsM), .o_vsync(vsM), .o_rgb(rgbM)
    );

    gol_display_scan #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CELL_PX(1), .BORDER_EN(1'b0)
    ) dutUnit (
        .i_clk(clk), .i_start(start), .i_grid_in(64'hFFFF_FFFF_FFFF_FFFF), .i_grid_valid(gridValid),
        .o_frame_done(fdU), .o_de(deU), .o_hsync(hsU), .o_vsync(vsU), .o_rgb(rgbU)
    );

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] expRgb(input int h, input int v, input int cp, input logic [63:0] disp);
        int cx, cy;
        if (!(h < 16 && v < 16)) return 24'h000000;
        cx = h / cp;
        cy = v / cp;
        if (cx >= 8 || cy >= 8) return 24'h202020;
        return disp[63 - 8 * cy - cx] ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Reference model: raster position comes from elapsed cycles since reset release.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start) begin
                checkOutput("rst_de", {23'b0, deM}, 24'd0);
                checkOutput("rst_hsync", {23'b0, hsM}, 24'd1);
                checkOutput("rst_vsync", {23'b0, vsM}, 24'd1);
                checkOutput("rst_rgb", rgbM, 24'd0);
                checkOutput("rst_fd", {23'b0, fdM}, 24'd0);
                checkOutput("rst_rgb_unit", rgbU, 24'd0);
                for (int k = 0; k < 2; k++) begin
                    mDisp[k]  = '0;
                    mPend[k]  = '0;
                    mPendV[k] = 1'b0;
                end
                tCnt    = 0;
                lastPos = -1;
            end else begin
                int p, h, v;
                logic expDe, expHs, expVs, expFd;
                p = tCnt % FT;
                h = p % HT;
                v = p / HT;
                expDe = (h < 16) && (v < 16);
                expHs = !(h == 18 || h == 19);
                expVs = (v != 17);
                expFd = (h == HT - 1) && (v == 15);
                checkOutput("de", {23'b0, deM}, {23'b0, expDe});
                checkOutput("hsync", {23'b0, hsM}, {23'b0, expHs});
                checkOutput("vsync", {23'b0, vsM}, {23'b0, expVs});
                checkOutput("frame_done", {23'b0, fdM}, {23'b0, expFd});
                checkOutput("rgb", rgbM, expRgb(h, v, 2, mDisp[0]));
                checkOutput("de_unit", {23'b0, deU}, {23'b0, expDe});
                checkOutput("rgb_unit", rgbU, expRgb(h, v, 1, mDisp[1]));
                for (int k = 0; k < 2; k++) begin
                    if (expFd && mPendV[k]) begin
                        mDisp[k]  = mPend[k];
                        mPendV[k] = 1'b0;
                    end
                    if (gridValid) begin
                        mPend[k]  = (k == 0) ? gridIn : 64'hFFFF_FFFF_FFFF_FFFF;
                        mPendV[k] = 1'b1;
                    end
                end
                lastPos = p;
                tCnt++;
            end
        end
    end

    task automatic waitPos(input int h, input int v);
        int p, n;
        p = v * HT + h;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (lastPos != p && n < 2 * FT);
        if (lastPos != p) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL wait_pos(%0d,%0d): got position %0d expected %0d", h, v, lastPos, p);
        end
    endtask

    // Strobe so that the DUT samples grid_valid on the edge where the raster sits at (h,v).
    task automatic applyStimulus(input int h, input int v, input logic [63:0] g);
        int prev;
        prev = (v * HT + h + FT - 1) % FT;
        waitPos(prev % HT, prev / HT);
        @(negedge clk);
        gridIn    = g;
        gridValid = 1'b1;
        @(negedge clk);
        gridValid = 1'b0;
    endtask

    initial begin
        start     = 1'b1;
        gridIn    = '0;
        gridValid = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Idle raster, nothing loaded.
        waitPos(0, 0);
        checkOutput("t1_de_0_0", {23'b0, deM}, 24'd1);
        checkOutput("t1_rgb_0_0", rgbM, 24'h000000);
        waitPos(16, 0);
        checkOutput("t1_de_16_0", {23'b0, deM}, 24'd0);
        waitPos(18, 0);
        checkOutput("t1_hsync_18_0", {23'b0, hsM}, 24'd0);
        waitPos(20, 0);
        checkOutput("t1_hsync_20_0", {23'b0, hsM}, 24'd1);
        waitPos(8, 0);
        checkOutput("t1_unit_bg_8_0", rgbU, 24'h202020);
        waitPos(21, 15);
        checkOutput("t1_fd_21_15", {23'b0, fdM}, 24'd1);
        waitPos(0, 16);
        checkOutput("t1_fd_0_16", {23'b0, fdM}, 24'd0);
        waitPos(0, 17);
        checkOutput("t1_vsync_0_17", {23'b0, vsM}, 24'd0);

        // Glider loaded mid-frame: invisible until the following frame.
        applyStimulus(3, 5, 64'h4020_E000_0000_0000);
        waitPos(2, 6);
        checkOutput("t2_same_frame_2_6", rgbM, 24'h000000);
        waitPos(0, 0);
        checkOutput("t2_rgb_0_0", rgbM, 24'h000000);
        waitPos(2, 0);
        checkOutput("t2_rgb_2_0", rgbM, 24'hFFFFFF);
        waitPos(7, 0);
        checkOutput("t6_unit_7_0", rgbU, 24'hFFFFFF);
        waitPos(8, 0);
        checkOutput("t6_unit_8_0", rgbU, 24'h202020);
        waitPos(3, 1);
        checkOutput("t2_rgb_3_1", rgbM, 24'hFFFFFF);
        waitPos(0, 4);
        checkOutput("t2_rgb_0_4", rgbM, 24'hFFFFFF);
        waitPos(1, 5);
        checkOutput("t2_rgb_1_5", rgbM, 24'hFFFFFF);
        waitPos(7, 7);
        checkOutput("t6_unit_7_7", rgbU, 24'hFFFFFF);
        waitPos(0, 8);
        checkOutput("t6_unit_0_8", rgbU, 24'h202020);

        // Latest strobe before the swap wins.
        applyStimulus(0, 3, 64'h8000_0000_0000_0000);
        applyStimulus(0, 6, 64'h0000_0000_0000_0001);
        waitPos(0, 0);
        checkOutput("t3_rgb_0_0", rgbM, 24'h000000);
        waitPos(14, 14);
        checkOutput("t3_rgb_14_14", rgbM, 24'hFFFFFF);
        waitPos(15, 15);
        checkOutput("t3_rgb_15_15", rgbM, 24'hFFFFFF);

        // Strobe on the swap cycle itself is deferred by one frame.
        applyStimulus(0, 3, 64'h8000_0000_0000_0000);
        applyStimulus(21, 15, 64'h0000_0000_0000_0001);
        waitPos(0, 0);
        checkOutput("t4_showsA_0_0", rgbM, 24'hFFFFFF);
        waitPos(14, 14);
        checkOutput("t4_showsA_14_14", rgbM, 24'h000000);
        waitPos(21, 15);
        checkOutput("t4_fd_21_15", {23'b0, fdM}, 24'd1);
        waitPos(0, 0);
        checkOutput("t4_showsB_0_0", rgbM, 24'h000000);
        checkOutput("t4_fd_0_0", {23'b0, fdM}, 24'd0);
        waitPos(15, 15);
        checkOutput("t4_showsB_15_15", rgbM, 24'hFFFFFF);

        // Asynchronous reset mid-line while a glider is on screen.
        applyStimulus(0, 3, 64'h4020_E000_0000_0000);
        waitPos(2, 0);
        checkOutput("t5_glider_2_0", rgbM, 24'hFFFFFF);
        waitPos(6, 9);
        start = 1'b1;
        #1;
        checkOutput("t5_async_de", {23'b0, deM}, 24'd0);
        checkOutput("t5_async_hsync", {23'b0, hsM}, 24'd1);
        checkOutput("t5_async_vsync", {23'b0, vsM}, 24'd1);
        checkOutput("t5_async_rgb", rgbM, 24'h000000);
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitPos(0, 0);
        checkOutput("t5_restart_de", {23'b0, deM}, 24'd1);
        checkOutput("t5_restart_unit_0_0", rgbU, 24'h000000);
        waitPos(2, 0);
        checkOutput("t5_cleared_2_0", rgbM, 24'h000000);
        waitPos(0, 4);
        checkOutput("t5_cleared_0_4", rgbM, 24'h000000);
        waitPos(0, 0);
        checkOutput("t5_next_frame_de", {23'b0, deM}, 24'd1);
        waitPos(2, 0);
        checkOutput("t5_next_frame_2_0", rgbM, 24'h000000);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
